mem_access_seq: RTL

- Sequential successor to the combinational memory-stage decode in the RISC-V core.
- Accepts one load/store per handshake from EX/MEM and registers the region enables, byte write mask and aligned store data.
- Forwards store data from a parametrised window of older in-flight results.
- Holds a multi-cycle valid/ready transaction to the IO space, stalling the pipe until it completes.

---
 rtl/mem_access_seq.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_seq.sv
// Memory-stage access sequencer: registers region enables, byte mask and store data.
// Optional IO_TIMEOUT_EN macro adds an abort counter to the IO wait state.
module mem_access_seq #(
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned IO_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_inst,
  input  logic [31:0]            req_pc,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_rd2,
  input  logic [FWD_DEPTH-1:0]   fwd_valid,
  input  logic [32*FWD_DEPTH-1:0] fwd_inst,
  input  logic [32*FWD_DEPTH-1:0] fwd_data,
  output logic                   imem_en,
  output logic                   dmem_en,
  output logic                   bios_en,
  output logic                   io_en,
  output logic [3:0]             mem_we,
  output logic [31:0]            mem_wdata,
  output logic                   io_valid,
  input  logic                   io_ready,
  output logic                   stall,
  output logic                   done,
  output logic                   err_align,
  output logic                   err_map
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_IO_WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        imem_q, imem_d, dmem_q, dmem_d, bios_q, bios_d, io_en_q, io_en_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        io_valid_q, io_valid_d, done_q, done_d;
  logic        err_align_q, err_align_d, err_map_q, err_map_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs2;
  logic [3:0]  region;
  logic [1:0]  off;
  logic        is_load, is_store, misalign, mapped;
  logic        dec_imem, dec_dmem, dec_bios, dec_io;
  logic [3:0]  dec_we;
  logic [31:0] st_data, dec_wdata;
  logic        accept, io_timeout;

  assign opcode = req_inst[6:0];
  assign funct3 = req_inst[14:12];
  assign rs2    = req_inst[24:20];
  assign region = req_addr[31:28];
  assign off    = req_addr[1:0];

  assign is_load  = (opcode == OP_LOAD) &&
                    (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign is_store = (opcode == OP_STORE) && (funct3 inside {3'b000, 3'b001, 3'b010});
  assign misalign = ((funct3[1:0] == 2'b01) && off[0]) ||
                    ((funct3[1:0] == 2'b10) && (off != 2'b00));

  // Per-entry forwarding match; only instructions that actually write rd qualify
  logic [FWD_DEPTH-1:0] fwd_hit;
  logic [31:0]          fwd_word [FWD_DEPTH];

  for (genvar g = 0; g < FWD_DEPTH; g++) begin : g_fwd
    logic [6:0] f_op;
    logic [4:0] f_rd;
    logic       unused_hi;
    assign f_op        = fwd_inst[32*g +: 7];
    assign f_rd        = fwd_inst[32*g+7 +: 5];
    assign unused_hi   = ^fwd_inst[32*g+12 +: 20];
    assign fwd_word[g] = fwd_data[32*g +: 32];
    assign fwd_hit[g]  = fwd_valid[g] && (f_op != OP_STORE) && (f_op != OP_BRANCH) &&
                         (f_op != OP_SYSTEM) && (f_rd != 5'd0) && (f_rd == rs2);
  end

  // Youngest matching entry wins, so scan from oldest and let lower indices overwrite
  always_comb begin
    st_data = req_rd2;
    for (int i = int'(FWD_DEPTH) - 1; i >= 0; i--) begin
      if (fwd_hit[i]) st_data = fwd_word[i];
    end
  end

  always_comb begin
    dec_imem = 1'b0;
    dec_dmem = 1'b0;
    dec_bios = 1'b0;
    dec_io   = 1'b0;
    if (is_load) begin
      dec_io   = (region == 4'b1000);
      dec_bios = (region == 4'b0100);
      dec_dmem = (region[3:2] == 2'b00) && region[0];
    end else if (is_store) begin
      if (region == 4'b1000) begin
        dec_io = 1'b1;
      end else begin
        dec_dmem = req_addr[28];
        dec_imem = req_addr[29] & req_pc[30];
      end
    end
  end

  assign mapped = dec_imem | dec_dmem | dec_bios | dec_io;

  always_comb begin
    dec_we    = 4'b0000;
    dec_wdata = 32'h0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00:   dec_we = 4'b0001 << off;
        2'b01:   dec_we = 4'b0011 << off;
        default: dec_we = 4'b1111;
      endcase
      dec_wdata = st_data << {off, 3'b000};
    end
  end

  assign req_ready = (state_q != ST_IO_WAIT);
  assign stall     = req_valid & ~req_ready;
  assign accept    = req_valid & req_ready;

`ifdef IO_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(IO_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d      = (state_q == ST_IO_WAIT) ? cnt_q + CNT_W'(1) : '0;
  assign io_timeout = (state_q == ST_IO_WAIT) && (cnt_q == CNT_W'(IO_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign io_timeout = 1'b0;
`endif

  logic unused_c;
  assign unused_c = ^{req_inst[31:25], req_inst[19:15], req_inst[11:7], req_pc[31],
                      req_pc[29:0], req_addr[27:2], 32'(IO_TIMEOUT)};

  // Next state and next registered outputs; pulses default low every cycle
  always_comb begin
    state_d     = state_q;
    imem_d      = 1'b0;
    dmem_d      = 1'b0;
    bios_d      = 1'b0;
    io_en_d     = 1'b0;
    we_d        = 4'b0000;
    wdata_d     = 32'h0;
    io_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_align_d = 1'b0;
    err_map_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_ISSUE: begin
        state_d = ST_IDLE;
        if (accept && (is_load || is_store)) begin
          if (misalign) begin
            err_align_d = 1'b1;
          end else if (!mapped) begin
            err_map_d = 1'b1;
          end else if (dec_io) begin
            state_d    = ST_IO_WAIT;
            io_en_d    = 1'b1;
            io_valid_d = 1'b1;
            we_d       = dec_we;
            wdata_d    = dec_wdata;
          end else begin
            state_d = ST_ISSUE;
            imem_d  = dec_imem;
            dmem_d  = dec_dmem;
            bios_d  = dec_bios;
            we_d    = dec_we;
            wdata_d = dec_wdata;
            done_d  = 1'b1;
          end
        end
      end
      ST_IO_WAIT: begin
        if (io_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (io_timeout) begin
          state_d   = ST_IDLE;
          err_map_d = 1'b1;
        end else begin
          io_en_d    = 1'b1;
          io_valid_d = 1'b1;
          we_d       = we_q;
          wdata_d    = wdata_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      imem_q      <= 1'b0;
      dmem_q      <= 1'b0;
      bios_q      <= 1'b0;
      io_en_q     <= 1'b0;
      we_q        <= 4'b0000;
      wdata_q     <= 32'h0;
      io_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_align_q <= 1'b0;
      err_map_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_q      <= imem_d;
      dmem_q      <= dmem_d;
      bios_q      <= bios_d;
      io_en_q     <= io_en_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      io_valid_q  <= io_valid_d;
      done_q      <= done_d;
      err_align_q <= err_align_d;
      err_map_q   <= err_map_d;
    end
  end

  assign imem_en   = imem_q;
  assign dmem_en   = dmem_q;
  assign bios_en   = bios_q;
  assign io_en     = io_en_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign io_valid  = io_valid_q;
  assign done      = done_q;
  assign err_align = err_align_q;
  assign err_map   = err_map_q;

endmodule
